// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared defaults, constants and types for the hazard controller
package pipe_hazard_ctrl_pkg;

  localparam int DEF_REG_W    = 5;
  localparam int DEF_RING_LEN = 5;
  localparam int DEF_MC_LAT   = 4;
  localparam int DEF_CNT_W    = 16;

  // Wide enough for the largest multicycle latency (255).
  localparam int MC_CNT_W = 8;

  // Register 0 is hardwired, so it never creates a dependency.
  localparam int ZERO_REG = 0;

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_DEP,
    HZ_MULTI
  } hz_kind_e;

endpackage

// File: rtl/hazard_mc_counter.sv
// rtl/hazard_mc_counter.sv - EXE occupancy counter for multicycle ops, drives hold and busy
module hazard_mc_counter
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MC_LAT = DEF_MC_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic start_req,
  output logic hold,
  output logic busy
);

  logic [MC_CNT_W-1:0] cnt_q;
  logic [MC_CNT_W-1:0] cnt_d;
  logic                start;

  // A new op is only accepted once the previous one has fully drained.
  always_comb begin
    start = start_req && (cnt_q == '0) && (MC_LAT > 1);
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = MC_CNT_W'(MC_LAT - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - MC_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The start cycle plus counts MC_LAT-1 down to 2 give MC_LAT-1 hold cycles.
  assign hold = start || (cnt_q > MC_CNT_W'(1));
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush generation for load-use, branch and multicycle hazards
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W    = DEF_REG_W,
  parameter int RING_LEN = DEF_RING_LEN,
  parameter int MC_LAT   = DEF_MC_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             Jump_IN,
  input  logic             Branch_IN,
  input  logic [REG_W-1:0] IDRegRS_IN,
  input  logic [REG_W-1:0] IDRegRT_IN,
  input  logic [REG_W-1:0] IDEXEWriteReg_IN,
  input  logic             IDEXEWriteEnable_IN,
  input  logic             IDEXEMemRead_IN,
  input  logic [REG_W-1:0] EXEMEMWriteReg_IN,
  input  logic             EXEMEMMemRead_IN,
  input  logic             MultiStart_IN,
  output logic             STALL_IFID,
  output logic             FLUSH_IFID,
  output logic             STALL_IDEXE,
  output logic             FLUSH_IDEXE,
  output logic             STALL_EXEMEM,
  output logic             FLUSH_EXEMEM,
  output logic             STALL_MEMWB,
  output logic             FLUSH_MEMWB,
  output logic             MultiBusy_OUT,
  output logic [CNT_W-1:0] HazardCount_OUT
);

  logic [RING_LEN-1:0] ring_q;
  logic [RING_LEN-1:0] ring_d;
  logic [CNT_W-1:0]    hz_cnt_q;
  logic [CNT_W-1:0]    hz_cnt_d;
  logic                lu;
  logic                br;
  logic                mh;
  logic                hz;
  hz_kind_e            kind;

  function automatic logic reg_match(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
    return (dst != REG_W'(ZERO_REG)) && (dst == src);
  endfunction

  hazard_mc_counter #(
    .MC_LAT (MC_LAT)
  ) u_mc_counter (
    .clk       (CLOCK),
    .rst       (RESET),
    .start_req (MultiStart_IN),
    .hold      (mh),
    .busy      (MultiBusy_OUT)
  );

  always_comb begin
    lu = IDEXEMemRead_IN &&
         (reg_match(IDEXEWriteReg_IN, IDRegRS_IN) || reg_match(IDEXEWriteReg_IN, IDRegRT_IN));
    br = (Branch_IN || Jump_IN) &&
         ((IDEXEWriteEnable_IN &&
           (reg_match(IDEXEWriteReg_IN, IDRegRS_IN) || reg_match(IDEXEWriteReg_IN, IDRegRT_IN))) ||
          (EXEMEMMemRead_IN &&
           (reg_match(EXEMEMWriteReg_IN, IDRegRS_IN) || reg_match(EXEMEMWriteReg_IN, IDRegRT_IN))));
    hz = mh || lu || br;

    if (mh) begin
      kind = HZ_MULTI;
    end else if (lu || br) begin
      kind = HZ_DEP;
    end else begin
      kind = HZ_NONE;
    end
  end

  // Off-slot fetch cycles stall IFID and bubble it, unless a hazard already holds the front end.
  always_comb begin
    STALL_IFID   = !ring_q[0];
    FLUSH_IFID   = !ring_q[0] && !hz;
    STALL_IDEXE  = 1'b0;
    FLUSH_IDEXE  = 1'b0;
    STALL_EXEMEM = 1'b0;
    FLUSH_EXEMEM = 1'b0;
    STALL_MEMWB  = 1'b0;
    FLUSH_MEMWB  = 1'b0;
    case (kind)
      HZ_MULTI: begin
        STALL_IFID   = 1'b1;
        STALL_IDEXE  = 1'b1;
        FLUSH_EXEMEM = 1'b1;
      end
      HZ_DEP: begin
        STALL_IFID  = 1'b1;
        FLUSH_IDEXE = 1'b1;
      end
      default: ;
    endcase
  end

  // Rotate-left works for RING_LEN=1 too: the shifted-out term is zero and the wrap term is the bit itself.
  always_comb begin
    ring_d   = (ring_q << 1) | (ring_q >> (RING_LEN - 1));
    hz_cnt_d = hz_cnt_q;
    if (hz && (hz_cnt_q != '1)) begin
      hz_cnt_d = hz_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ring_q   <= RING_LEN'(1);
      hz_cnt_q <= '0;
    end else begin
      ring_q   <= ring_d;
      hz_cnt_q <= hz_cnt_d;
    end
  end

  assign HazardCount_OUT = hz_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for the pipeline hazard controller
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic        j;
    logic        b;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  exr;
    logic        exwe;
    logic        exld;
    logic [4:0]  mmr;
    logic        mmld;
    logic        ms;
    logic        rst;
    logic [8:0]  ctl;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    logic [8:0]  ctl;
    logic [15:0] cnt;
  } exp_t;

  // {STALL_IFID, FLUSH_IFID, STALL_IDEXE, FLUSH_IDEXE, STALL_EXEMEM, FLUSH_EXEMEM, STALL_MEMWB, FLUSH_MEMWB, MultiBusy}
  localparam logic [8:0] C_IDLE = 9'b000000000;
  localparam logic [8:0] C_GAP  = 9'b110000000;
  localparam logic [8:0] C_DEP  = 9'b100100000;
  localparam logic [8:0] C_MH   = 9'b101001000;
  localparam logic [8:0] C_BUSY = 9'b000000001;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       Jump_IN, Branch_IN, IDEXEWriteEnable_IN, IDEXEMemRead_IN, EXEMEMMemRead_IN, MultiStart_IN;
  logic [4:0] IDRegRS_IN, IDRegRT_IN, IDEXEWriteReg_IN, EXEMEMWriteReg_IN;

  logic a_sifid, a_fifid, a_sidexe, a_fidexe, a_sexmem, a_fexmem, a_smemwb, a_fmemwb, a_busy;
  logic b_sifid, b_fifid, b_sidexe, b_fidexe, b_sexmem, b_fexmem, b_smemwb, b_fmemwb, b_busy;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;
  logic [8:0]  ctl_a, ctl_b;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  always #5 CLOCK = ~CLOCK;

  assign ctl_a = {a_sifid, a_fifid, a_sidexe, a_fidexe, a_sexmem, a_fexmem, a_smemwb, a_fmemwb, a_busy};
  assign ctl_b = {b_sifid, b_fifid, b_sidexe, b_fidexe, b_sexmem, b_fexmem, b_smemwb, b_fmemwb, b_busy};

  pipe_hazard_ctrl dut_a (
    .CLOCK(CLOCK), .RESET(RESET), .Jump_IN(Jump_IN), .Branch_IN(Branch_IN),
    .IDRegRS_IN(IDRegRS_IN), .IDRegRT_IN(IDRegRT_IN), .IDEXEWriteReg_IN(IDEXEWriteReg_IN),
    .IDEXEWriteEnable_IN(IDEXEWriteEnable_IN), .IDEXEMemRead_IN(IDEXEMemRead_IN),
    .EXEMEMWriteReg_IN(EXEMEMWriteReg_IN), .EXEMEMMemRead_IN(EXEMEMMemRead_IN),
    .MultiStart_IN(MultiStart_IN),
    .STALL_IFID(a_sifid), .FLUSH_IFID(a_fifid), .STALL_IDEXE(a_sidexe), .FLUSH_IDEXE(a_fidexe),
    .STALL_EXEMEM(a_sexmem), .FLUSH_EXEMEM(a_fexmem), .STALL_MEMWB(a_smemwb), .FLUSH_MEMWB(a_fmemwb),
    .MultiBusy_OUT(a_busy), .HazardCount_OUT(a_cnt)
  );

  pipe_hazard_ctrl #(.RING_LEN(1), .MC_LAT(4), .CNT_W(4)) dut_b (
    .CLOCK(CLOCK), .RESET(RESET), .Jump_IN(Jump_IN), .Branch_IN(Branch_IN),
    .IDRegRS_IN(IDRegRS_IN), .IDRegRT_IN(IDRegRT_IN), .IDEXEWriteReg_IN(IDEXEWriteReg_IN),
    .IDEXEWriteEnable_IN(IDEXEWriteEnable_IN), .IDEXEMemRead_IN(IDEXEMemRead_IN),
    .EXEMEMWriteReg_IN(EXEMEMWriteReg_IN), .EXEMEMMemRead_IN(EXEMEMMemRead_IN),
    .MultiStart_IN(MultiStart_IN),
    .STALL_IFID(b_sifid), .FLUSH_IFID(b_fifid), .STALL_IDEXE(b_sidexe), .FLUSH_IDEXE(b_fidexe),
    .STALL_EXEMEM(b_sexmem), .FLUSH_EXEMEM(b_fexmem), .STALL_MEMWB(b_smemwb), .FLUSH_MEMWB(b_fmemwb),
    .MultiBusy_OUT(b_busy), .HazardCount_OUT(b_cnt)
  );

  function automatic vec_t mk(input logic j, input logic b, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] exr, input logic exwe, input logic exld,
                              input logic [4:0] mmr, input logic mmld, input logic ms, input logic rst,
                              input logic [8:0] ctl, input logic [15:0] cnt);
    vec_t v;
    v.j = j; v.b = b; v.rs = rs; v.rt = rt; v.exr = exr; v.exwe = exwe; v.exld = exld;
    v.mmr = mmr; v.mmld = mmld; v.ms = ms; v.rst = rst; v.ctl = ctl; v.cnt = cnt;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    Jump_IN = v.j; Branch_IN = v.b; IDRegRS_IN = v.rs; IDRegRT_IN = v.rt;
    IDEXEWriteReg_IN = v.exr; IDEXEWriteEnable_IN = v.exwe; IDEXEMemRead_IN = v.exld;
    EXEMEMWriteReg_IN = v.mmr; EXEMEMMemRead_IN = v.mmld; MultiStart_IN = v.ms; RESET = v.rst;
    exp_q.push_back('{ctl: v.ctl, cnt: v.cnt});
  endtask

  task automatic do_reset();
    apply_vec(mk(L, L, 5'd0, 5'd0, 5'd0, L, L, 5'd0, L, L, H, C_IDLE, 16'd0));
    void'(exp_q.pop_front());
    @(posedge CLOCK); #1;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    exp_q.push_back('{ctl: C_IDLE, cnt: 16'd0});
    @(negedge CLOCK);
    e = exp_q.pop_front();
    vectors++;
    if (ctl_a !== e.ctl) begin miscompares++; $display("FAIL reset ctl_a: got %b want %b", ctl_a, e.ctl); end
    vectors++;
    if (ctl_b !== e.ctl) begin miscompares++; $display("FAIL reset ctl_b: got %b want %b", ctl_b, e.ctl); end
    vectors++;
    if (a_cnt !== e.cnt) begin miscompares++; $display("FAIL reset cnt_a: got %0d want %0d", a_cnt, e.cnt); end
    vectors++;
    if (b_cnt !== e.cnt[3:0]) begin miscompares++; $display("FAIL reset cnt_b: got %0d want %0d", b_cnt, e.cnt[3:0]); end
    @(posedge CLOCK); #1;
  endtask

  task automatic test_ring();
    exp_t e;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      apply_vec(mk(L, L, 5'd0, 5'd0, 5'd0, L, L, 5'd0, L, L, L, (k % 5 == 0) ? C_IDLE : C_GAP, 16'd0));
      @(negedge CLOCK);
      e = exp_q.pop_front();
      vectors++;
      if (ctl_a !== e.ctl) begin miscompares++; $display("FAIL ring ctl_a cycle %0d: got %b want %b", k, ctl_a, e.ctl); end
      vectors++;
      if (ctl_b !== C_IDLE) begin miscompares++; $display("FAIL ring ctl_b cycle %0d: got %b want %b", k, ctl_b, C_IDLE); end
      vectors++;
      if (a_cnt !== e.cnt) begin miscompares++; $display("FAIL ring cnt_a cycle %0d: got %0d want %0d", k, a_cnt, e.cnt); end
      @(posedge CLOCK); #1;
    end
  endtask

  task automatic test_load_use();
    vec_t tab[$];
    exp_t e;
    do_reset();
    tab.push_back(mk(L, L, 5'd0, 5'd8, 5'd8, L, H, 5'd0, L, L, L, C_DEP,  16'd0));
    tab.push_back(mk(L, L, 5'd8, 5'd2, 5'd8, L, H, 5'd0, L, L, L, C_DEP,  16'd1));
    tab.push_back(mk(L, L, 5'd1, 5'd2, 5'd8, L, H, 5'd0, L, L, L, C_IDLE, 16'd2));
    tab.push_back(mk(L, L, 5'd0, 5'd8, 5'd8, H, L, 5'd0, L, L, L, C_IDLE, 16'd2));
    tab.push_back(mk(L, L, 5'd0, 5'd0, 5'd0, L, L, 5'd0, L, L, L, C_IDLE, 16'd2));
    foreach (tab[k]) begin
      apply_vec(tab[k]);
      @(negedge CLOCK);
      e = exp_q.pop_front();
      vectors++;
      if (ctl_b !== e.ctl) begin miscompares++; $display("FAIL load_use ctl row %0d: got %b want %b", k, ctl_b, e.ctl); end
      vectors++;
      if (b_cnt !== e.cnt[3:0]) begin miscompares++; $display("FAIL load_use cnt row %0d: got %0d want %0d", k, b_cnt, e.cnt[3:0]); end
      @(posedge CLOCK); #1;
    end
  endtask

  task automatic test_reg_zero();
    vec_t tab[$];
    exp_t e;
    do_reset();
    tab.push_back(mk(L, L, 5'd0, 5'd0, 5'd0, L, H, 5'd0, L, L, L, C_IDLE, 16'd0));
    tab.push_back(mk(L, H, 5'd0, 5'd0, 5'd0, L, L, 5'd0, H, L, L, C_IDLE, 16'd0));
    tab.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, H, L, 5'd0, L, L, L, C_IDLE, 16'd0));
    tab.push_back(mk(L, L, 5'd0, 5'd0, 5'd0, L, L, 5'd0, L, L, L, C_IDLE, 16'd0));
    foreach (tab[k]) begin
      apply_vec(tab[k]);
      @(negedge CLOCK);
      e = exp_q.pop_front();
      vectors++;
      if (ctl_b !== e.ctl) begin miscompares++; $display("FAIL reg_zero ctl row %0d: got %b want %b", k, ctl_b, e.ctl); end
      vectors++;
      if (b_cnt !== e.cnt[3:0]) begin miscompares++; $display("FAIL reg_zero cnt row %0d: got %0d want %0d", k, b_cnt, e.cnt[3:0]); end
      @(posedge CLOCK); #1;
    end
  endtask

  task automatic test_branch();
    vec_t tab[$];
    exp_t e;
    do_reset();
    tab.push_back(mk(L, H, 5'd3, 5'd0, 5'd0, L, L, 5'd3, H, L, L, C_DEP,  16'd0));
    tab.push_back(mk(H, L, 5'd0, 5'd5, 5'd5, H, L, 5'd0, L, L, L, C_DEP,  16'd1));
    tab.push_back(mk(L, H, 5'd0, 5'd5, 5'd5, L, L, 5'd0, L, L, L, C_IDLE, 16'd2));
    tab.push_back(mk(L, L, 5'd3, 5'd0, 5'd0, L, L, 5'd3, H, L, L, C_IDLE, 16'd2));
    tab.push_back(mk(L, H, 5'd3, 5'd0, 5'd0, L, L, 5'd3, L, L, L, C_IDLE, 16'd2));
    tab.push_back(mk(H, L, 5'd0, 5'd7, 5'd0, L, L, 5'd7, H, L, L, C_DEP,  16'd2));
    tab.push_back(mk(L, L, 5'd0, 5'd0, 5'd0, L, L, 5'd0, L, L, L, C_IDLE, 16'd3));
    foreach (tab[k]) begin
      apply_vec(tab[k]);
      @(negedge CLOCK);
      e = exp_q.pop_front();
      vectors++;
      if (ctl_b !== e.ctl) begin miscompares++; $display("FAIL branch ctl row %0d: got %b want %b", k, ctl_b, e.ctl); end
      vectors++;
      if (b_cnt !== e.cnt[3:0]) begin miscompares++; $display("FAIL branch cnt row %0d: got %0d want %0d", k, b_cnt, e.cnt[3:0]); end
      @(posedge CLOCK); #1;
    end
  endtask

  task automatic test_multicycle();
    vec_t tab[$];
    exp_t e;
    do_reset();
    tab.push_back(mk(L, L, 5'd0, 5'd8, 5'd8, L, H, 5'd0, L, H, L, C_MH,           16'd0));
    tab.push_back(mk(L, L, 5'd0, 5'd8, 5'd8, L, H, 5'd0, L, H, L, C_MH | C_BUSY,  16'd1));
    tab.push_back(mk(L, L, 5'd0, 5'd8, 5'd8, L, H, 5'd0, L, H, L, C_MH | C_BUSY,  16'd2));
    tab.push_back(mk(L, L, 5'd0, 5'd8, 5'd8, L, H, 5'd0, L, H, L, C_DEP | C_BUSY, 16'd3));
    tab.push_back(mk(L, L, 5'd0, 5'd0, 5'd0, L, L, 5'd0, L, L, L, C_IDLE,         16'd4));
    foreach (tab[k]) begin
      apply_vec(tab[k]);
      @(negedge CLOCK);
      e = exp_q.pop_front();
      vectors++;
      if (ctl_b !== e.ctl) begin miscompares++; $display("FAIL multicycle ctl row %0d: got %b want %b", k, ctl_b, e.ctl); end
      vectors++;
      if (b_cnt !== e.cnt[3:0]) begin miscompares++; $display("FAIL multicycle cnt row %0d: got %0d want %0d", k, b_cnt, e.cnt[3:0]); end
      @(posedge CLOCK); #1;
    end
  endtask

  task automatic test_back_to_back();
    vec_t tab[$];
    exp_t e;
    logic [8:0]  pat [8] = '{C_MH, C_MH | C_BUSY, C_MH | C_BUSY, C_BUSY, C_MH, C_MH | C_BUSY, C_MH | C_BUSY, C_BUSY};
    logic [15:0] cnts [8] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd4, 16'd5, 16'd6};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tab.push_back(mk(L, L, 5'd0, 5'd0, 5'd0, L, L, 5'd0, L, H, L, pat[k], cnts[k]));
    end
    tab.push_back(mk(L, L, 5'd0, 5'd0, 5'd0, L, L, 5'd0, L, L, L, C_IDLE, 16'd6));
    foreach (tab[k]) begin
      apply_vec(tab[k]);
      @(negedge CLOCK);
      e = exp_q.pop_front();
      vectors++;
      if (ctl_b !== e.ctl) begin miscompares++; $display("FAIL back_to_back ctl row %0d: got %b want %b", k, ctl_b, e.ctl); end
      vectors++;
      if (b_cnt !== e.cnt[3:0]) begin miscompares++; $display("FAIL back_to_back cnt row %0d: got %0d want %0d", k, b_cnt, e.cnt[3:0]); end
      @(posedge CLOCK); #1;
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      apply_vec(mk(L, L, 5'd0, 5'd8, 5'd8, L, (k < 20) ? H : L, 5'd0, L, L, L,
                   (k < 20) ? C_DEP : C_IDLE, 16'(k)));
      @(negedge CLOCK);
      e = exp_q.pop_front();
      vectors++;
      if (a_cnt !== e.cnt) begin miscompares++; $display("FAIL saturate cnt_a cycle %0d: got %0d want %0d", k, a_cnt, e.cnt); end
      vectors++;
      if (b_cnt !== ((e.cnt > 16'd15) ? 4'd15 : e.cnt[3:0])) begin
        miscompares++;
        $display("FAIL saturate cnt_b cycle %0d: got %0d want %0d", k, b_cnt, (e.cnt > 16'd15) ? 4'd15 : e.cnt[3:0]);
      end
      vectors++;
      if (ctl_b !== e.ctl) begin miscompares++; $display("FAIL saturate ctl_b cycle %0d: got %b want %b", k, ctl_b, e.ctl); end
      @(posedge CLOCK); #1;
    end
  endtask

  task automatic test_reset_mid();
    vec_t tab[$];
    exp_t e;
    do_reset();
    tab.push_back(mk(L, L, 5'd0, 5'd0, 5'd0, L, L, 5'd0, L, H, L, C_MH,          16'd0));
    tab.push_back(mk(L, L, 5'd0, 5'd0, 5'd0, L, L, 5'd0, L, L, H, C_MH | C_BUSY, 16'd1));
    tab.push_back(mk(L, L, 5'd0, 5'd0, 5'd0, L, L, 5'd0, L, L, L, C_IDLE,        16'd0));
    tab.push_back(mk(L, L, 5'd0, 5'd0, 5'd0, L, L, 5'd0, L, H, L, C_MH,          16'd0));
    tab.push_back(mk(L, L, 5'd0, 5'd0, 5'd0, L, L, 5'd0, L, L, L, C_MH | C_BUSY, 16'd1));
    foreach (tab[k]) begin
      apply_vec(tab[k]);
      @(negedge CLOCK);
      e = exp_q.pop_front();
      vectors++;
      if (ctl_b !== e.ctl) begin miscompares++; $display("FAIL reset_mid ctl row %0d: got %b want %b", k, ctl_b, e.ctl); end
      vectors++;
      if (b_cnt !== e.cnt[3:0]) begin miscompares++; $display("FAIL reset_mid cnt_b row %0d: got %0d want %0d", k, b_cnt, e.cnt[3:0]); end
      vectors++;
      if (a_cnt !== e.cnt) begin miscompares++; $display("FAIL reset_mid cnt_a row %0d: got %0d want %0d", k, a_cnt, e.cnt); end
      @(posedge CLOCK); #1;
    end
    RESET = 1'b0;
    MultiStart_IN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Jump_IN = 1'b0; Branch_IN = 1'b0; IDRegRS_IN = '0; IDRegRT_IN = '0;
    IDEXEWriteReg_IN = '0; IDEXEWriteEnable_IN = 1'b0; IDEXEMemRead_IN = 1'b0;
    EXEMEMWriteReg_IN = '0; EXEMEMMemRead_IN = 1'b0; MultiStart_IN = 1'b0;
    test_reset();
    test_ring();
    test_load_use();
    test_reg_zero();
    test_branch();
    test_multicycle();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard drain: got %0d leftover want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
